studio2_mem_arbiter: RTL and testbench
======================================

// Module: studio2_mem_arbiter
// PURPOSE
// Arbitrates the single 4 KB system memory between the CDP1802 CPU, the CDP1861 (pixie) display DMA and the
// ioctl cartridge/ROM loader, and decodes the Studio II memory map onto it.
// - Sits between the CPU/pixie/ioctl ports and the dpram port A.
// - Stalls losing requesters and returns read data one cycle after the grant.
// - Enforces write protection and mirroring of the memory map.
// PARAMETERS
// STARVE_LIMIT  8  consecutive cycles the CPU may be denied by DMA before it wins one slot (1..255)
// PORTS
// clk_sys     in   1   system clock; all logic on rising edge
// resetq      in   1   synchronous reset, active-low
// cpu_rd      in   1   CPU read request (level, held while cpu_wait=1)
// cpu_wr      in   1   CPU write request (level, held while cpu_wait=1)
// cpu_addr    in   16  CPU address
// cpu_wdata   in   8   CPU write data
// cpu_wait    out  1   CPU request present and not granted this cycle
// cpu_rdata   out  8   CPU read data, valid with cpu_rvalid, held afterwards
// cpu_rvalid  out  1   1-cycle pulse, cycle after CPU read grant
// dma_req     in   1   pixie display-fetch request (read only)
// dma_addr    in   16  pixie fetch address
// dma_ack     out  1   DMA granted this cycle
// dma_rdata   out  8   DMA read data, valid with dma_rvalid, held afterwards
// dma_rvalid  out  1   1-cycle pulse, cycle after DMA grant
// ld_active   in   1   ioctl download in progress
// ld_wr       in   1   loader write strobe
// ld_addr     in   12  loader physical address
// ld_data     in   8   loader write data
// mem_ce      out  1   memory port enable
// mem_we      out  1   memory write enable
// mem_addr    out  12  physical memory address
// mem_wdata   out  8   memory write data
// mem_rdata   in   8   memory read data; 1-cycle registered latency
// BEHAVIOUR
// - Grant decided combinationally each cycle from current requests; mem_* driven same cycle (N); read data
//   captured at N+1 into the owner's rdata register, with rvalid pulsed at N+1.
// - Priority: loader (ld_active) > DMA > CPU, except starvation override below.
// - ld_active=1: only loader; cpu_wait=1 for any CPU request, dma_ack=0. mem_ce=mem_we=ld_wr, addr=ld_addr,
//   no protection. ld_active=0 -> normal arbitration from the next cycle.
// - Starve counter (8 bit): +1 each cycle CPU requests and loses to DMA; cleared on CPU grant or when CPU is
//   idle. At count==STARVE_LIMIT the CPU wins over DMA that cycle (dma_ack=0). Loader losses do not count.
// - Decode of cpu_addr/dma_addr:
//   000-7FF ROM/cart: read ok, CPU write dropped (cycle consumed)
//   800-9FF RAM: read/write
//   A00-BFF, E00-FFF multicart: read ok, CPU write dropped
//   C00-DFF mirror: mem_addr = {2'b10, a[9:0]}, read/write
// - Address bits [15:12] != 0 -> unmapped: no mem access (mem_ce=0). Read returns 8'hFF with normal 1-cycle
//   rvalid; write dropped. Still counts as a grant.
// - Dropped write: mem_ce=0, cpu_wait=0 (CPU completes). Simultaneous cpu_rd & cpu_wr: treated as write.
// - Read tag register (owner: none/CPU/DMA/FF) selects the N+1 destination. Back-to-back grants to alternating
//   owners are legal.
// - Reset (resetq=0 at edge): cpu_rvalid=dma_rvalid=0, cpu_rdata=dma_rdata=8'h00, tag=none, starve=0.
//   Combinational outputs follow inputs but no grant is issued while resetq=0: mem_ce=0, dma_ack=0, cpu_wait=0.
//   An in-flight read at reset is discarded, with no rvalid after reset.
// TESTING
// - CPU rd 0x0810 alone, mem_rdata=0x5A at N+1 -> mem_addr=0x810 at N, cpu_rvalid=1 and cpu_rdata=0x5A at N+1.
// - CPU wr 0x0C05=0x33 -> mem_we=1 with mem_addr=0x805. CPU wr 0x0100 -> mem_ce=0 and cpu_wait=0.
// - dma_req and cpu_rd held continuously, STARVE_LIMIT=8 -> 8 DMA acks with cpu_wait=1, then a CPU grant,
//   then repeat.
// - ld_active=1 with ld_wr to 0x000..0x3FF while CPU reads -> all writes reach mem, cpu_wait=1 throughout,
//   no starve increment.
// - CPU rd 0x1234 -> mem_ce=0, cpu_rvalid at N+1 with cpu_rdata=0xFF.
// - resetq=0 the cycle after a DMA grant -> dma_rvalid stays 0, all registers 0 next cycle.

Source files
------------

// File: rtl/studio2_mem_arbiter_if.sv
// Bus bundle between the Studio II requesters (CPU, pixie DMA, ioctl loader),
// the memory arbiter and the single-port system memory.
// The arbiter uses the slave view.
// The surrounding system (requesters plus memory) uses the master view.
interface studio2_mem_arbiter_if;
  // CDP1802 CPU port
  logic        cpu_rd;
  logic        cpu_wr;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wait;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;

  // CDP1861 display-fetch port (read only)
  logic        dma_req;
  logic [15:0] dma_addr;
  logic        dma_ack;
  logic [7:0]  dma_rdata;
  logic        dma_rvalid;

  // ioctl cartridge/ROM loader
  logic        ld_active;
  logic        ld_wr;
  logic [11:0] ld_addr;
  logic [7:0]  ld_data;

  // dpram port A
  logic        mem_ce;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_wait, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_addr,
    output dma_ack, dma_rdata, dma_rvalid,
    input  ld_active, ld_wr, ld_addr, ld_data,
    output mem_ce, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_wait, cpu_rdata, cpu_rvalid,
    output dma_req, dma_addr,
    input  dma_ack, dma_rdata, dma_rvalid,
    output ld_active, ld_wr, ld_addr, ld_data,
    input  mem_ce, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/studio2_mem_arbiter.sv
// Studio II memory arbiter.
// It shares the 4 KB system memory between the ioctl loader, the pixie
// display DMA and the CDP1802 CPU, and decodes the Studio II memory map
// (ROM/cart, RAM, RAM mirror, multicart, unmapped).
// A grant is decided combinationally in cycle N and drives the memory port
// in the same cycle. The read result is returned to its owner in cycle N+1,
// steered by a registered read tag.
module studio2_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                 clk_sys,
  input  logic                 resetq,
  studio2_mem_arbiter_if.slave bus
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);
  localparam logic [7:0] STARVE_MAX = 8'hFF;
  localparam logic [7:0] OPEN_BUS   = 8'hFF;

  // Owner of the read issued last cycle.
  // The _FF owners are unmapped reads: no memory access was made for them.
  typedef enum logic [2:0] {
    TAG_NONE,
    TAG_CPU,
    TAG_DMA,
    TAG_CPU_FF,
    TAG_DMA_FF
  } tag_e;

  tag_e        tag_q, tag_d;
  logic [7:0]  starve_q, starve_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic [7:0]  dma_rdata_q, dma_rdata_d;
  logic        cpu_rvalid_d, dma_rvalid_d;

  logic        cpu_req;
  logic        cpu_first;
  logic        mem_ce_d, mem_we_d;
  logic [11:0] mem_addr_d;
  logic [7:0]  mem_wdata_d;
  logic        cpu_wait_d, dma_ack_d;

  // Only the low 4 KB of the 16-bit space is backed by memory.
  function automatic logic is_mapped(input logic [3:0] hi);
    return hi == 4'h0;
  endfunction

  // CPU writes land only in RAM (800-9FF) and its mirror (C00-DFF).
  // All other blocks drop the write.
  function automatic logic cpu_writable(input logic [2:0] blk);
    return (blk == 3'b100) || (blk == 3'b110);
  endfunction

  // The C00-DFF mirror folds onto RAM at 800-9FF.
  // Every other block maps straight through.
  function automatic logic [11:0] phys_addr(input logic [11:0] a);
    logic [11:0] p;
    if (a[11:9] == 3'b110) begin
      p = {2'b10, a[9:0]};
    end else begin
      p = a;
    end
    return p;
  endfunction

  assign cpu_req = bus.cpu_rd | bus.cpu_wr;

  // Per-cycle grant decision, memory-port drive, next read tag and starve count
  always_comb begin
    mem_ce_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = 12'h000;
    mem_wdata_d = 8'h00;
    cpu_wait_d  = 1'b0;
    dma_ack_d   = 1'b0;
    tag_d       = TAG_NONE;
    starve_d    = starve_q;
    cpu_first   = 1'b0;

    if (!resetq) begin
      // No grant while reset is asserted.
      // The registers are cleared by the state process.
      starve_d = 8'h00;
    end else if (bus.ld_active) begin
      // The loader owns the port outright, with no map or write protection.
      mem_ce_d    = bus.ld_wr;
      mem_we_d    = bus.ld_wr;
      mem_addr_d  = bus.ld_addr;
      mem_wdata_d = bus.ld_data;
      cpu_wait_d  = cpu_req;
      // Losing to the loader leaves the starve count untouched.
      if (!cpu_req) begin
        starve_d = 8'h00;
      end
    end else begin
      cpu_first = cpu_req && (!bus.dma_req || (starve_q == STARVE_LIM));
      if (bus.dma_req && !cpu_first) begin
        dma_ack_d  = 1'b1;
        cpu_wait_d = cpu_req;
        if (is_mapped(bus.dma_addr[15:12])) begin
          mem_ce_d   = 1'b1;
          mem_addr_d = phys_addr(bus.dma_addr[11:0]);
          tag_d      = TAG_DMA;
        end else begin
          tag_d      = TAG_DMA_FF;
        end
        if (!cpu_req) begin
          starve_d = 8'h00;
        end else if (starve_q != STARVE_MAX) begin
          starve_d = starve_q + 8'd1;
        end
      end else if (cpu_req) begin
        starve_d = 8'h00;
        if (bus.cpu_wr) begin
          // Protected or unmapped writes still consume the slot, so the CPU completes.
          if (is_mapped(bus.cpu_addr[15:12]) && cpu_writable(bus.cpu_addr[11:9])) begin
            mem_ce_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = phys_addr(bus.cpu_addr[11:0]);
            mem_wdata_d = bus.cpu_wdata;
          end
        end else begin
          if (is_mapped(bus.cpu_addr[15:12])) begin
            mem_ce_d   = 1'b1;
            mem_addr_d = phys_addr(bus.cpu_addr[11:0]);
            tag_d      = TAG_CPU;
          end else begin
            tag_d      = TAG_CPU_FF;
          end
        end
      end else begin
        starve_d = 8'h00;
      end
    end
  end

  // Read return: steer memory data (or open-bus FF) to last cycle's owner; otherwise hold
  always_comb begin
    cpu_rvalid_d = 1'b0;
    dma_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    // Gating with resetq drops a read still in flight when reset arrives.
    if (resetq) begin
      case (tag_q)
        TAG_CPU: begin
          cpu_rvalid_d = 1'b1;
          cpu_rdata_d  = bus.mem_rdata;
        end
        TAG_CPU_FF: begin
          cpu_rvalid_d = 1'b1;
          cpu_rdata_d  = OPEN_BUS;
        end
        TAG_DMA: begin
          dma_rvalid_d = 1'b1;
          dma_rdata_d  = bus.mem_rdata;
        end
        TAG_DMA_FF: begin
          dma_rvalid_d = 1'b1;
          dma_rdata_d  = OPEN_BUS;
        end
        default: begin
        end
      endcase
    end
  end

  // State registers: read tag, starve counter and the held read-data registers
  always_ff @(posedge clk_sys) begin
    if (!resetq) begin
      tag_q       <= TAG_NONE;
      starve_q    <= 8'h00;
      cpu_rdata_q <= 8'h00;
      dma_rdata_q <= 8'h00;
    end else begin
      tag_q       <= tag_d;
      starve_q    <= starve_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign bus.mem_ce     = mem_ce_d;
  assign bus.mem_we     = mem_we_d;
  assign bus.mem_addr   = mem_addr_d;
  assign bus.mem_wdata  = mem_wdata_d;
  assign bus.cpu_wait   = cpu_wait_d;
  assign bus.dma_ack    = dma_ack_d;
  assign bus.cpu_rdata  = cpu_rdata_d;
  assign bus.cpu_rvalid = cpu_rvalid_d;
  assign bus.dma_rdata  = dma_rdata_d;
  assign bus.dma_rvalid = dma_rvalid_d;

endmodule

// File: tb/tb_studio2_mem_arbiter.sv
// Bench for studio2_mem_arbiter.
// A driver applies stimulus each cycle and checks the grant and memory port
// against a reference model of the arbitration rules and memory map. The
// model also pushes expected read results into queues. A separate monitor
// pops those queues whenever an rvalid appears.
`timescale 1ns/1ps
module tb_studio2_mem_arbiter;
  localparam int LIMIT = 8;

  logic clk_sys = 1'b0;
  logic resetq  = 1'b0;
  always #5 clk_sys = ~clk_sys;

  studio2_mem_arbiter_if bus();

  studio2_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_sys (clk_sys),
    .resetq  (resetq),
    .bus     (bus)
  );

  // Synchronous memory with one cycle of read latency
  logic [7:0] sram [4096];
  logic [7:0] sram_q = 8'h00;
  always @(posedge clk_sys) begin
    if (bus.mem_ce) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
      else            sram_q <= sram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = sram_q;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t cpu_q[$];
  exp_t dma_q[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // stimulus for the next cycle
  logic        s_resetq, s_cpu_rd, s_cpu_wr, s_dma_req, s_ld_active, s_ld_wr;
  logic [15:0] s_cpu_addr, s_dma_addr;
  logic [7:0]  s_cpu_wdata, s_ld_data;
  logic [11:0] s_ld_addr;

  // reference state
  logic [7:0] m_mem [4096];
  int         starve     = 0;
  logic       last_wait  = 1'b0;
  int         prev_owner = 0;
  logic       prev_reset = 1'b1;
  logic [7:0] held_cpu   = 8'h00;
  logic [7:0] held_dma   = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic in_map(input logic [15:0] a);
    return a < 16'h1000;
  endfunction

  function automatic int phys(input logic [15:0] a);
    if (a >= 16'h0C00 && a < 16'h0E00) return int'(a) - 'h400;
    return int'(a);
  endfunction

  function automatic logic may_write(input logic [15:0] a);
    return (a >= 16'h0800 && a < 16'h0A00) || (a >= 16'h0C00 && a < 16'h0E00);
  endfunction

  function automatic logic [15:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return {4'($urandom_range(1, 15)), 12'($urandom)};
    if (r < 5)  return (($urandom_range(0, 1) == 1) ? 16'h0800 : 16'h0C00) + 16'($urandom_range(0, 31));
    return 16'($urandom_range(0, 4095));
  endfunction

  task automatic set_idle();
    s_resetq = 1'b1; s_cpu_rd = 1'b0; s_cpu_wr = 1'b0; s_cpu_addr = 16'h0; s_cpu_wdata = 8'h0;
    s_dma_req = 1'b0; s_dma_addr = 16'h0; s_ld_active = 1'b0; s_ld_wr = 1'b0;
    s_ld_addr = 12'h0; s_ld_data = 8'h0;
  endtask

  // One clock: apply stimulus, evaluate the rules, compare the port, queue the read results
  task automatic step();
    logic cpu_req, cpu_first, ok, exp_wait;
    int   owner;
    exp_t e;
    @(posedge clk_sys); #1;
    cyc++;
    resetq        = s_resetq;
    bus.cpu_rd    = s_cpu_rd;    bus.cpu_wr    = s_cpu_wr;
    bus.cpu_addr  = s_cpu_addr;  bus.cpu_wdata = s_cpu_wdata;
    bus.dma_req   = s_dma_req;   bus.dma_addr  = s_dma_addr;
    bus.ld_active = s_ld_active; bus.ld_wr     = s_ld_wr;
    bus.ld_addr   = s_ld_addr;   bus.ld_data   = s_ld_data;
    if (prev_reset) begin
      held_cpu = 8'h00;
      held_dma = 8'h00;
    end
    #1;
    cpu_req  = s_cpu_rd | s_cpu_wr;
    owner    = 0;
    exp_wait = 1'b0;
    if (!s_resetq) begin
      if (prev_owner == 1) void'(cpu_q.pop_back());
      else if (prev_owner == 2) void'(dma_q.pop_back());
      starve = 0;
      chk("rst_mem_ce", bus.mem_ce, 0);
      chk("rst_dma_ack", bus.dma_ack, 0);
      chk("rst_cpu_wait", bus.cpu_wait, 0);
    end else if (s_ld_active) begin
      exp_wait = cpu_req;
      if (!cpu_req) starve = 0;
      chk("ld_cpu_wait", bus.cpu_wait, cpu_req);
      chk("ld_dma_ack", bus.dma_ack, 0);
      chk("ld_mem_ce", bus.mem_ce, s_ld_wr);
      if (s_ld_wr) begin
        chk("ld_mem_we", bus.mem_we, 1);
        chk("ld_mem_addr", bus.mem_addr, s_ld_addr);
        chk("ld_mem_wdata", bus.mem_wdata, s_ld_data);
        m_mem[s_ld_addr] = s_ld_data;
      end
    end else begin
      cpu_first = cpu_req && (!s_dma_req || starve == LIMIT);
      if (s_dma_req && !cpu_first) begin
        exp_wait = cpu_req;
        starve   = cpu_req ? starve + 1 : 0;
        chk("dma_ack", bus.dma_ack, 1);
        chk("cpu_wait_vs_dma", bus.cpu_wait, cpu_req);
        ok = in_map(s_dma_addr);
        chk("dma_mem_ce", bus.mem_ce, ok);
        if (ok) begin
          chk("dma_mem_we", bus.mem_we, 0);
          chk("dma_mem_addr", bus.mem_addr, phys(s_dma_addr));
        end
        e.data = ok ? m_mem[phys(s_dma_addr)] : 8'hFF;
        e.due  = cyc + 1;
        dma_q.push_back(e);
        owner = 2;
      end else if (cpu_req) begin
        starve = 0;
        chk("cpu_grant_dma_ack", bus.dma_ack, 0);
        chk("cpu_grant_wait", bus.cpu_wait, 0);
        if (s_cpu_wr) begin
          ok = in_map(s_cpu_addr) && may_write(s_cpu_addr);
          chk("cpu_wr_mem_ce", bus.mem_ce, ok);
          if (ok) begin
            chk("cpu_wr_mem_we", bus.mem_we, 1);
            chk("cpu_wr_mem_addr", bus.mem_addr, phys(s_cpu_addr));
            chk("cpu_wr_mem_wdata", bus.mem_wdata, s_cpu_wdata);
            m_mem[phys(s_cpu_addr)] = s_cpu_wdata;
          end
        end else begin
          ok = in_map(s_cpu_addr);
          chk("cpu_rd_mem_ce", bus.mem_ce, ok);
          if (ok) begin
            chk("cpu_rd_mem_we", bus.mem_we, 0);
            chk("cpu_rd_mem_addr", bus.mem_addr, phys(s_cpu_addr));
          end
          e.data = ok ? m_mem[phys(s_cpu_addr)] : 8'hFF;
          e.due  = cyc + 1;
          cpu_q.push_back(e);
          owner = 1;
        end
      end else begin
        starve = 0;
        chk("idle_dma_ack", bus.dma_ack, 0);
        chk("idle_cpu_wait", bus.cpu_wait, 0);
        chk("idle_mem_ce", bus.mem_ce, 0);
      end
    end
    last_wait  = exp_wait;
    prev_owner = owner;
    prev_reset = !s_resetq;
  endtask

  // Monitor: consume expected read results as rvalid pulses appear, and check held data otherwise
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_sys);
      if (bus.cpu_rvalid === 1'b1) begin
        if (cpu_q.size() == 0) begin
          chk("cpu_rvalid_unexpected", 1, 0);
        end else begin
          e = cpu_q.pop_front();
          chk("cpu_rvalid_cycle", cyc, e.due);
          chk("cpu_rdata", bus.cpu_rdata, e.data);
          held_cpu = e.data;
        end
      end else if (resetq) begin
        chk("cpu_rdata_held", bus.cpu_rdata, held_cpu);
      end
      while (cpu_q.size() > 0 && cpu_q[0].due < cyc) begin
        e = cpu_q.pop_front();
        chk("cpu_rvalid_missing", 0, 1);
      end
      if (bus.dma_rvalid === 1'b1) begin
        if (dma_q.size() == 0) begin
          chk("dma_rvalid_unexpected", 1, 0);
        end else begin
          e = dma_q.pop_front();
          chk("dma_rvalid_cycle", cyc, e.due);
          chk("dma_rdata", bus.dma_rdata, e.data);
          held_dma = e.data;
        end
      end else if (resetq) begin
        chk("dma_rdata_held", bus.dma_rdata, held_dma);
      end
      while (dma_q.size() > 0 && dma_q[0].due < cyc) begin
        e = dma_q.pop_front();
        chk("dma_rvalid_missing", 0, 1);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    for (int i = 0; i < 4096; i++) m_mem[i] = 8'h00;
    set_idle();

    // reset with requests present: no grants
    s_resetq = 1'b0; s_cpu_rd = 1'b1; s_cpu_addr = 16'h0810; s_dma_req = 1'b1;
    step(); step();
    set_idle(); step(); step();

    // loader fills the whole memory while CPU and DMA both request
    s_ld_active = 1'b1; s_cpu_rd = 1'b1; s_cpu_addr = 16'h0810;
    s_dma_req = 1'b1; s_dma_addr = 16'h0900;
    for (int a = 0; a < 4096; a++) begin
      s_ld_wr = 1'b1; s_ld_addr = 12'(a); s_ld_data = 8'($urandom);
      step();
    end
    s_ld_wr = 1'b0; step(); step();

    // loader released with CPU and DMA held: DMA streak, then one CPU slot, repeating
    s_ld_active = 1'b0;
    for (int i = 0; i < 30; i++) begin
      s_dma_addr = 16'($urandom_range(0, 4095));
      step();
    end
    set_idle(); step();

    // directed CPU accesses
    s_cpu_rd = 1'b1; s_cpu_addr = 16'h0810; step();
    set_idle(); s_cpu_wr = 1'b1; s_cpu_addr = 16'h0C05; s_cpu_wdata = 8'h33; step();
    set_idle(); s_cpu_rd = 1'b1; s_cpu_addr = 16'h0805; step();
    set_idle(); s_cpu_wr = 1'b1; s_cpu_addr = 16'h0100; s_cpu_wdata = 8'hA5; step();
    set_idle(); s_cpu_rd = 1'b1; s_cpu_addr = 16'h0100; step();
    set_idle(); s_cpu_rd = 1'b1; s_cpu_addr = 16'h1234; step();
    set_idle(); s_cpu_wr = 1'b1; s_cpu_addr = 16'h5678; s_cpu_wdata = 8'h11; step();
    set_idle(); s_cpu_rd = 1'b1; s_cpu_wr = 1'b1; s_cpu_addr = 16'h0A10; s_cpu_wdata = 8'h77; step();
    set_idle(); s_cpu_rd = 1'b1; s_cpu_addr = 16'h0A10; step();
    set_idle(); step();

    // DMA grant followed by reset: the read is discarded
    s_dma_req = 1'b1; s_dma_addr = 16'h0900; step();
    set_idle(); s_resetq = 1'b0; step();
    set_idle(); step(); step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (!last_wait) begin
        r = $urandom_range(0, 9);
        s_cpu_rd    = (r <= 3) || (r == 8);
        s_cpu_wr    = (r >= 4 && r <= 6) || (r == 8);
        s_cpu_addr  = rand_addr();
        s_cpu_wdata = 8'($urandom);
      end
      s_dma_req   = ($urandom_range(0, 1) == 1);
      s_dma_addr  = rand_addr();
      s_ld_active = ($urandom_range(0, 39) == 0);
      s_ld_wr     = ($urandom_range(0, 1) == 1);
      s_ld_addr   = 12'($urandom);
      s_ld_data   = 8'($urandom);
      s_resetq    = ($urandom_range(0, 149) != 0);
      step();
    end

    set_idle(); step(); step(); step();
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("dma_q_drained", dma_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
